// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write slave: collects AW and W in either order, issues one backend write pulse,
// then holds the B response until the master accepts it. One write outstanding at a time.
module axi_lite_write_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    wr_err
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ADDR_LSB;

    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_e;

    state_e                  state_q, state_d;
    logic                    aw_cap_q, aw_cap_d;
    logic                    w_cap_q, w_cap_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic                    live_q;
    logic                    aw_hs, w_hs;

    // live_q keeps the readys low while reset is held and for the release cycle itself
    assign awready = (state_q == IDLE) && live_q && !aw_cap_q;
    assign wready  = (state_q == IDLE) && live_q && !w_cap_q;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    assign wr_en   = (state_q == WRITE);
    assign bvalid  = (state_q == RESP);
    assign bresp   = bresp_q;
    assign wr_addr = addr_q;
    assign wr_data = data_q;
    assign wr_strb = strb_q;

    always_comb begin
        state_d  = state_q;
        aw_cap_d = aw_cap_q;
        w_cap_d  = w_cap_q;
        bresp_d  = bresp_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strb_d   = strb_q;
        unique case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    aw_cap_d = 1'b1;
                    addr_d   = awaddr & ADDR_MASK;
                end
                if (w_hs) begin
                    w_cap_d = 1'b1;
                    data_d  = wdata;
                    strb_d  = wstrb;
                end
                if (aw_cap_d && w_cap_d) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                bresp_d  = wr_err ? 2'b10 : 2'b00;
                aw_cap_d = 1'b0;
                w_cap_d  = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                if (bready) begin
                    bresp_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            aw_cap_q <= 1'b0;
            w_cap_q  <= 1'b0;
            bresp_q  <= 2'b00;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            aw_cap_q <= aw_cap_d;
            w_cap_q  <= w_cap_d;
            bresp_q  <= bresp_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
            live_q   <= 1'b1;
        end
    end

endmodule
